// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared Avalon-MM request/response types and arbiter master ids.
// Types for the veriRISCV core buses plus the helpers used by the bus arbiter.
package avalon_bus_arbiter_pkg;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  byte_enable;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        waitrequest;
      logic        readdatavalid;
   } avalon_resp_t;

   localparam logic ARB_IBUS = 1'b0;
   localparam logic ARB_DBUS = 1'b1;

   function automatic logic avalon_is_req(input avalon_req_t r);
      return r.read | r.write;
   endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO; records which master issued each outstanding read.
// Extra pointer MSB distinguishes full from empty when the index bits match.
module arb_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      empty_o  = (wr_ptr_q == rd_ptr_q);
      full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head_o   = mem_q[rd_ptr_q[AW-1:0]];
      pop_ok   = pop_i & ~empty_o;
      // A push into a full FIFO is legal only when the same cycle frees a slot.
      push_ok  = push_i & (~full_o | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave Avalon-MM arbiter with round-robin grant,
// stall lock and in-order read-response routing.
module avalon_bus_arbiter
   import avalon_bus_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  avalon_req_t  ibus_avalon_req,
   output avalon_resp_t ibus_avalon_resp,
   input  avalon_req_t  dbus_avalon_req,
   output avalon_resp_t dbus_avalon_resp,
   output avalon_req_t  mem_avalon_req,
   input  avalon_resp_t mem_avalon_resp
);

   logic        last_grant_q, last_grant_d;
   logic        lock_q, lock_d;
   logic        lock_id_q, lock_id_d;
   logic        err_underflow_q, err_underflow_d;
   logic        err_underflow;

   logic        ireq, dreq;
   logic        grant;
   avalon_req_t sel_req;
   logic        sel_valid;
   logic        blocked;
   logic        eff_wait;
   logic        accept;
   logic        presented;
   logic        push;
   logic        pop;
   logic        fifo_full, fifo_empty;
   logic        fifo_head;

   // Grant selection: a held lock wins, otherwise round-robin on a tie.
   always_comb begin
      ireq = avalon_is_req(ibus_avalon_req);
      dreq = avalon_is_req(dbus_avalon_req);
      if (lock_q) begin
         grant = lock_id_q;
      end else if (ireq && dreq) begin
         grant = ~last_grant_q;
      end else if (dreq) begin
         grant = ARB_DBUS;
      end else begin
         grant = ARB_IBUS;
      end
      if (grant == ARB_DBUS) begin
         sel_req   = dbus_avalon_req;
         sel_valid = dreq;
      end else begin
         sel_req   = ibus_avalon_req;
         sel_valid = ireq;
      end
   end

   // A read may still go out on a full FIFO when a response frees a slot now.
   always_comb begin
      pop      = mem_avalon_resp.readdatavalid & ~fifo_empty & ~rst;
      blocked  = sel_valid & sel_req.read & fifo_full & ~pop;
      eff_wait = mem_avalon_resp.waitrequest | blocked;
      accept   = sel_valid & ~eff_wait & ~rst;
      push     = accept & sel_req.read;
   end

   always_comb begin
      mem_avalon_req = '0;
      if (!rst && sel_valid) begin
         mem_avalon_req = sel_req;
         if (blocked) begin
            mem_avalon_req.read = 1'b0;
         end else begin
            mem_avalon_req.read = sel_req.read;
         end
      end else begin
         mem_avalon_req = '0;
      end
      presented = mem_avalon_req.read | mem_avalon_req.write;
   end

   always_comb begin
      ibus_avalon_resp.readdata      = mem_avalon_resp.readdata;
      dbus_avalon_resp.readdata      = mem_avalon_resp.readdata;
      ibus_avalon_resp.waitrequest   = rst | (grant != ARB_IBUS) | eff_wait;
      dbus_avalon_resp.waitrequest   = rst | (grant != ARB_DBUS) | eff_wait;
      ibus_avalon_resp.readdatavalid = pop & (fifo_head == ARB_IBUS);
      dbus_avalon_resp.readdatavalid = pop & (fifo_head == ARB_DBUS);
   end

   // Next state for grant history, stall lock and the underflow flag.
   always_comb begin
      last_grant_d    = last_grant_q;
      lock_d          = lock_q;
      lock_id_d       = lock_id_q;
      err_underflow_d = err_underflow_q;
      if (accept) begin
         last_grant_d = grant;
         lock_d       = 1'b0;
      end else if (presented && mem_avalon_resp.waitrequest) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end else begin
         lock_d = lock_q;
      end
      if (mem_avalon_resp.readdatavalid && fifo_empty) begin
         err_underflow_d = 1'b1;
      end else begin
         err_underflow_d = err_underflow_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q    <= ARB_DBUS;
         lock_q          <= 1'b0;
         lock_id_q       <= ARB_IBUS;
         err_underflow_q <= 1'b0;
      end else begin
         last_grant_q    <= last_grant_d;
         lock_q          <= lock_d;
         lock_id_q       <= lock_id_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign err_underflow = err_underflow_q;

   arb_tag_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (grant),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed self-checking bench for avalon_bus_arbiter with a response scoreboard.
module tb_avalon_bus_arbiter;
   import avalon_bus_arbiter_pkg::*;

   logic         clk;
   logic         rst;
   avalon_req_t  ibus_req, dbus_req, mem_req;
   avalon_resp_t ibus_resp, dbus_resp, mem_resp;

   int   checks;
   int   errors;
   logic sb_q[$];
   logic [2:0] fifo_cnt;

   avalon_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .ibus_avalon_req  (ibus_req),
      .ibus_avalon_resp (ibus_resp),
      .dbus_avalon_req  (dbus_req),
      .dbus_avalon_resp (dbus_resp),
      .mem_avalon_req   (mem_req),
      .mem_avalon_resp  (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resp(input logic [31:0] data);
      logic exp_id;
      mem_resp.readdatavalid = 1'b1;
      mem_resp.readdata      = data;
      @(negedge clk);
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      exp_id = sb_q.pop_front();
      chk("ibus_rdv", 32'(ibus_resp.readdatavalid), 32'(exp_id == ARB_IBUS));
      chk("dbus_rdv", 32'(dbus_resp.readdatavalid), 32'(exp_id == ARB_DBUS));
      chk("rdata", exp_id ? dbus_resp.readdata : ibus_resp.readdata, data);
      tick();
      mem_resp.readdatavalid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      ibus_req = '0;
      dbus_req = '0;
      mem_resp = '0;
      rst      = 1'b1;
      ibus_req.read    = 1'b1;
      ibus_req.address = 32'h0000_0100;
      #3;
      chk("rst_mem_read", 32'(mem_req.read), 32'd0);
      chk("rst_mem_write", 32'(mem_req.write), 32'd0);
      chk("rst_mem_addr", mem_req.address, 32'd0);
      chk("rst_ibus_wait", 32'(ibus_resp.waitrequest), 32'd1);
      chk("rst_dbus_wait", 32'(dbus_resp.waitrequest), 32'd1);
      chk("rst_ibus_rdv", 32'(ibus_resp.readdatavalid), 32'd0);
      tick();
      rst = 1'b0;
      ibus_req = '0;
      chk("rst_last_grant", 32'(dut.last_grant_q), 32'd1);
      chk("rst_fifo_empty", 32'(dut.u_tag_fifo.empty_o), 32'd1);

      // Tie round-robin
      ibus_req.read = 1'b1; ibus_req.address = 32'h0000_0100;
      dbus_req.read = 1'b1; dbus_req.address = 32'h0000_2000;
      @(negedge clk);
      chk("t1_c0_addr", mem_req.address, 32'h0000_0100);
      chk("t1_c0_read", 32'(mem_req.read), 32'd1);
      chk("t1_c0_ibus_wait", 32'(ibus_resp.waitrequest), 32'd0);
      chk("t1_c0_dbus_wait", 32'(dbus_resp.waitrequest), 32'd1);
      sb_q.push_back(ARB_IBUS);
      tick();
      ibus_req = '0;
      @(negedge clk);
      chk("t1_c1_addr", mem_req.address, 32'h0000_2000);
      chk("t1_c1_dbus_wait", 32'(dbus_resp.waitrequest), 32'd0);
      sb_q.push_back(ARB_DBUS);
      tick();
      dbus_req = '0;
      resp(32'h0000_AAAA);
      resp(32'h0000_BBBB);

      // Lock across a 3-cycle stall
      dbus_req.write = 1'b1; dbus_req.address = 32'h0000_3000;
      dbus_req.writedata = 32'h1234_5678; dbus_req.byte_enable = 4'hF;
      mem_resp.waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            ibus_req.read = 1'b1; ibus_req.address = 32'h0000_0104;
         end
         @(negedge clk);
         chk("t2_stall_addr", mem_req.address, 32'h0000_3000);
         chk("t2_stall_write", 32'(mem_req.write), 32'd1);
         chk("t2_stall_wdata", mem_req.writedata, 32'h1234_5678);
         chk("t2_stall_dbus_wait", 32'(dbus_resp.waitrequest), 32'd1);
         chk("t2_stall_ibus_wait", 32'(ibus_resp.waitrequest), 32'd1);
         tick();
      end
      mem_resp.waitrequest = 1'b0;
      @(negedge clk);
      chk("t2_acc_addr", mem_req.address, 32'h0000_3000);
      chk("t2_acc_dbus_wait", 32'(dbus_resp.waitrequest), 32'd0);
      tick();
      dbus_req = '0;
      @(negedge clk);
      chk("t2_ibus_addr", mem_req.address, 32'h0000_0104);
      chk("t2_ibus_read", 32'(mem_req.read), 32'd1);
      chk("t2_ibus_wait", 32'(ibus_resp.waitrequest), 32'd0);
      sb_q.push_back(ARB_IBUS);
      tick();
      ibus_req = '0;
      resp(32'h0000_1111);

      // Full FIFO
      ibus_req.read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ibus_req.address = 32'h0000_0200 + 32'(i * 4);
         @(negedge clk);
         chk("t3_fill_wait", 32'(ibus_resp.waitrequest), 32'd0);
         sb_q.push_back(ARB_IBUS);
         tick();
      end
      ibus_req.address = 32'h0000_0210;
      @(negedge clk);
      chk("t3_full_wait", 32'(ibus_resp.waitrequest), 32'd1);
      chk("t3_full_mem_read", 32'(mem_req.read), 32'd0);
      chk("t3_full_flag", 32'(dut.u_tag_fifo.full_o), 32'd1);
      tick();
      mem_resp.readdatavalid = 1'b1;
      mem_resp.readdata      = 32'h0000_00C0;
      @(negedge clk);
      chk("t3_pop_ibus_rdv", 32'(ibus_resp.readdatavalid), 32'(sb_q.pop_front() == ARB_IBUS));
      chk("t3_pop_ibus_wait", 32'(ibus_resp.waitrequest), 32'd0);
      chk("t3_pop_mem_read", 32'(mem_req.read), 32'd1);
      chk("t3_pop_addr", mem_req.address, 32'h0000_0210);
      sb_q.push_back(ARB_IBUS);
      tick();
      ibus_req = '0;
      mem_resp.readdatavalid = 1'b0;
      fifo_cnt = dut.u_tag_fifo.wr_ptr_q - dut.u_tag_fifo.rd_ptr_q;
      chk("t3_count", 32'(fifo_cnt), 32'd4);
      for (int i = 0; i < 4; i++) resp(32'h0000_0C10 + 32'(i));

      // Write does not consume a tag
      dbus_req.write = 1'b1; dbus_req.address = 32'h0000_4000;
      tick();
      dbus_req = '0;
      ibus_req.read = 1'b1; ibus_req.address = 32'h0000_0300;
      sb_q.push_back(ARB_IBUS);
      tick();
      ibus_req = '0;
      dbus_req.read = 1'b1; dbus_req.address = 32'h0000_4004;
      sb_q.push_back(ARB_DBUS);
      tick();
      dbus_req = '0;
      fifo_cnt = dut.u_tag_fifo.wr_ptr_q - dut.u_tag_fifo.rd_ptr_q;
      chk("t4_count", 32'(fifo_cnt), 32'd2);
      resp(32'h0000_4A4A);
      resp(32'h0000_4B4B);

      // Reset mid-flight
      dbus_req.read = 1'b1; dbus_req.address = 32'h0000_0600;
      tick();
      dbus_req = '0;
      ibus_req.read = 1'b1; ibus_req.address = 32'h0000_0500;
      tick();
      ibus_req.address = 32'h0000_0504;
      chk("t5_pre_last_grant", 32'(dut.last_grant_q), 32'd0);
      #1;
      chk("t5_pre_mem_read", 32'(mem_req.read), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_rst_mem_read", 32'(mem_req.read), 32'd0);
      chk("t5_rst_ibus_wait", 32'(ibus_resp.waitrequest), 32'd1);
      chk("t5_rst_dbus_wait", 32'(dbus_resp.waitrequest), 32'd1);
      chk("t5_rst_empty", 32'(dut.u_tag_fifo.empty_o), 32'd1);
      tick();
      rst = 1'b0;
      ibus_req = '0;
      sb_q.delete();
      chk("t5_post_last_grant", 32'(dut.last_grant_q), 32'd1);
      chk("t5_post_empty", 32'(dut.u_tag_fifo.empty_o), 32'd1);
      chk("t5_err_clear", 32'(dut.err_underflow), 32'd0);
      mem_resp.readdatavalid = 1'b1;
      mem_resp.readdata      = 32'h0000_DEAD;
      @(negedge clk);
      chk("t5_stray_ibus_rdv", 32'(ibus_resp.readdatavalid), 32'd0);
      chk("t5_stray_dbus_rdv", 32'(dbus_resp.readdatavalid), 32'd0);
      tick();
      mem_resp.readdatavalid = 1'b0;
      chk("t5_err_set", 32'(dut.err_underflow), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
